// File: rtl/gpu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpu_cmd_ctrl
// Description : Host-side command controller for the VGA text GPU. Takes
//               bytes from an asynchronous 8-bit 4-phase bus, decodes
//               multi-byte commands, keeps cursor/attribute state and
//               sequences writes (single cells and screen fills) into VRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_cmd_ctrl #(
    parameter int COLS        = 80,
    parameter int ROWS        = 30,
    parameter int ADDR_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [7:0]        i_data,
    output logic              o_ack,
    output logic              o_busy,
    output logic [7:0]        o_status,
    output logic              o_vram_we,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic [15:0]       o_vram_data,
    output logic [ADDR_W-1:0] o_cursor,
    output logic              o_err
);

    localparam int CELLS = COLS * ROWS;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_ARG  = 4'd1;
    localparam logic [3:0] ST_EXEC = 4'd2;
    localparam logic [3:0] ST_FILL = 4'd3;

    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_SET_CURSOR = 8'h01;
    localparam logic [7:0] OP_PUT_CHAR   = 8'h02;
    localparam logic [7:0] OP_SET_ATTR   = 8'h03;
    localparam logic [7:0] OP_CLEAR      = 8'h04;

    logic [SYNC_STAGES-1:0] en_sync;
    logic [SYNC_STAGES-1:0] we_sync;
    logic                   en_s;
    logic                   we_s;

    logic [3:0]        state;
    logic [3:0]        next_state;
    logic              busy;
    logic              fill_active;

    logic              ack;
    logic [7:0]        status;
    logic              err;
    logic [7:0]        attr;
    logic [7:0]        opcode;
    logic              arg_cnt;
    logic [7:0]        arg0;
    logic [7:0]        arg1;
    logic [ADDR_W-1:0] cursor;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [15:0]       vram_data;

    logic              consume;
    logic              wr_byte;
    logic              rd_byte;
    logic              last_arg;
    logic [COL_W-1:0]  col_set;
    logic [ROW_W-1:0]  row_set;
    logic [ADDR_W-1:0] cursor_set;

    // Bring the asynchronous host strobes into the clock domain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            en_sync <= '0;
            we_sync <= '0;
        end else begin
            en_sync <= {en_sync[SYNC_STAGES-2:0], i_en};
            we_sync <= {we_sync[SYNC_STAGES-2:0], i_we};
        end
    end

    assign en_s = en_sync[SYNC_STAGES-1];
    assign we_s = we_sync[SYNC_STAGES-1];

    // A byte is taken once per strobe, and only while not executing
    assign consume  = en_s & ~ack & ~busy;
    assign wr_byte  = consume & we_s;
    assign rd_byte  = consume & ~we_s;
    assign last_arg = (opcode != OP_SET_CURSOR) | arg_cnt;

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state decode
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (wr_byte) begin
                    case (i_data)
                        OP_SET_CURSOR, OP_PUT_CHAR, OP_SET_ATTR: next_state = ST_ARG;
                        OP_CLEAR:                                next_state = ST_FILL;
                        default:                                 next_state = ST_IDLE;
                    endcase
                end
            end
            ST_ARG: begin
                if (wr_byte && last_arg) begin
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: next_state = ST_IDLE;
            ST_FILL: begin
                if (vram_addr == LAST_ADDR) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy        = (state == ST_EXEC) || (state == ST_FILL);
        fill_active = (state == ST_FILL);
    end

    // Clamp SET_CURSOR arguments to the screen and form the linear address
    always_comb begin
        col_set    = (32'(arg0) > 32'(COLS - 1)) ? LAST_COL : COL_W'(arg0);
        row_set    = (32'(arg1) > 32'(ROWS - 1)) ? LAST_ROW : ROW_W'(arg1);
        cursor_set = ADDR_W'(row_set) * ADDR_W'(COLS) + ADDR_W'(col_set);
    end

    // Handshake, command registers, cursor tracking and VRAM write port
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack       <= 1'b0;
            status    <= 8'h00;
            err       <= 1'b0;
            attr      <= 8'h0F;
            opcode    <= 8'h00;
            arg_cnt   <= 1'b0;
            arg0      <= 8'h00;
            arg1      <= 8'h00;
            cursor    <= '0;
            col       <= '0;
            row       <= '0;
            vram_we   <= 1'b0;
            vram_addr <= '0;
            vram_data <= 16'h0000;
        end else begin
            ack     <= consume | (ack & en_s);
            vram_we <= 1'b0;

            if (rd_byte) begin
                status <= {err, busy, 1'b0, fill_active, state};
            end

            if (wr_byte) begin
                case (state)
                    ST_IDLE: begin
                        opcode  <= i_data;
                        arg_cnt <= 1'b0;
                        case (i_data)
                            OP_NOP: err <= 1'b0;
                            OP_SET_CURSOR, OP_PUT_CHAR, OP_SET_ATTR: ;
                            OP_CLEAR: begin
                                // First fill write goes out in the first FILL cycle
                                vram_we   <= 1'b1;
                                vram_addr <= '0;
                                vram_data <= {attr, 8'h20};
                                cursor    <= '0;
                                col       <= '0;
                                row       <= '0;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                    ST_ARG: begin
                        arg_cnt <= 1'b1;
                        if (!arg_cnt) begin
                            arg0 <= i_data;
                        end else begin
                            arg1 <= i_data;
                        end
                        // Character write is launched so it is visible during EXEC
                        if (opcode == OP_PUT_CHAR) begin
                            vram_we   <= 1'b1;
                            vram_addr <= cursor;
                            vram_data <= {attr, i_data};
                        end
                    end
                    default: ;
                endcase
            end else if (state == ST_EXEC) begin
                case (opcode)
                    OP_SET_CURSOR: begin
                        cursor <= cursor_set;
                        col    <= col_set;
                        row    <= row_set;
                    end
                    OP_PUT_CHAR: begin
                        // Advance with counters only; last cell wraps to the origin
                        if (col == LAST_COL) begin
                            col <= '0;
                            if (row == LAST_ROW) begin
                                row    <= '0;
                                cursor <= '0;
                            end else begin
                                row    <= row + ROW_W'(1);
                                cursor <= cursor + ADDR_W'(1);
                            end
                        end else begin
                            col    <= col + COL_W'(1);
                            cursor <= cursor + ADDR_W'(1);
                        end
                    end
                    OP_SET_ATTR: attr <= arg0;
                    default: ;
                endcase
            end else if (state == ST_FILL) begin
                if (vram_addr != LAST_ADDR) begin
                    vram_we   <= 1'b1;
                    vram_addr <= vram_addr + ADDR_W'(1);
                end
            end
        end
    end

    assign o_ack       = ack;
    assign o_busy      = busy;
    assign o_status    = status;
    assign o_vram_we   = vram_we;
    assign o_vram_addr = vram_addr;
    assign o_vram_data = vram_data;
    assign o_cursor    = cursor;
    assign o_err       = err;

endmodule
`default_nettype wire

// File: tb/tb_gpu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_cmd_ctrl
// Description : Directed self-checking bench for gpu_cmd_ctrl with a VRAM
//               write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_cmd_ctrl;

    localparam int COLS        = 80;
    localparam int ROWS        = 30;
    localparam int ADDR_W      = 12;
    localparam int SYNC_STAGES = 2;
    localparam int CELLS       = COLS * ROWS;
    localparam int TIMEOUT     = 10000;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              en    = 1'b0;
    logic              we    = 1'b0;
    logic [7:0]        data  = 8'h00;
    logic              ack;
    logic              busy;
    logic [7:0]        status;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [15:0]       vram_data;
    logic [ADDR_W-1:0] cursor;
    logic              err;

    int                errors      = 0;
    int                checks      = 0;
    int                writes      = 0;
    int                busy_cycles = 0;
    bit                sb_ignore   = 1'b0;
    logic [27:0]       sb[$];

    always #5 clk = ~clk;

    gpu_cmd_ctrl #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_we        (we),
        .i_data      (data),
        .o_ack       (ack),
        .o_busy      (busy),
        .o_status    (status),
        .o_vram_we   (vram_we),
        .o_vram_addr (vram_addr),
        .o_vram_data (vram_data),
        .o_cursor    (cursor),
        .o_err       (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for o_ack to reach a level; returns clock edges waited
    task automatic wait_ack(input logic level, output int n);
        n = 0;
        while (ack !== level && n < TIMEOUT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ack_wait", {63'd0, ack}, {63'd0, level});
    endtask

    task automatic bus_cycle(input logic w, input logic [7:0] b, output logic [7:0] st);
        int n;
        we   = w;
        data = b;
        en   = 1'b1;
        wait_ack(1'b1, n);
        st = status;
        en = 1'b0;
        wait_ack(1'b0, n);
    endtask

    task automatic wr(input logic [7:0] b);
        logic [7:0] st;
        bus_cycle(1'b1, b, st);
    endtask

    task automatic rd(output logic [7:0] st);
        bus_cycle(1'b0, 8'h00, st);
    endtask

    initial begin
        int          n;
        int          w0;
        int          b0;
        logic [7:0]  st;
        logic [27:0] exp_wr;

        // Scoreboard consumer and activity counters
        fork
            forever begin
                @(negedge clk);
                if (busy) busy_cycles++;
                if (vram_we) begin
                    writes++;
                    if (!sb_ignore) begin
                        checks++;
                        assert (sb.size() != 0) else begin
                            errors++;
                            $error("FAIL vram_unexpected: observed write addr=%0d data=0x%0h expected none",
                                   vram_addr, vram_data);
                        end
                        if (sb.size() != 0) begin
                            exp_wr = sb.pop_front();
                            check("vram_write", {36'd0, vram_addr, vram_data}, {36'd0, exp_wr});
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {12'd0, ack, busy, status, vram_we, vram_addr, vram_data, cursor, err}, 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Handshake latency on a status read
        we = 1'b0;
        en = 1'b1;
        wait_ack(1'b1, n);
        check("ack_rise_latency", 64'(n), 64'd3);
        check("status_idle", {56'd0, status}, 64'h00);
        en = 1'b0;
        wait_ack(1'b0, n);
        check("ack_fall_latency", 64'(n), 64'd3);

        // Cursor to last cell, write 'A', cursor wraps to origin
        wr(8'h01); wr(8'd79); wr(8'd29);
        check("cursor_set_last", 64'(cursor), 64'd2399);
        sb.push_back({12'd2399, 16'h0F41});
        wr(8'h02); wr(8'h41);
        check("cursor_wrap", 64'(cursor), 64'd0);
        check("sb_drain_A", 64'(sb.size()), 64'd0);

        // End of row advances to the next row
        wr(8'h01); wr(8'd79); wr(8'd0);
        sb.push_back({12'd79, 16'h0F43});
        wr(8'h02); wr(8'h43);
        check("cursor_row_advance", 64'(cursor), 64'd80);

        // Clamped cursor, new attribute, write 'B'
        wr(8'h01); wr(8'd200); wr(8'd200);
        check("cursor_clamped", 64'(cursor), 64'd2399);
        wr(8'h03); wr(8'h1E);
        sb.push_back({12'd2399, 16'h1E42});
        wr(8'h02); wr(8'h42);
        check("sb_drain_B", 64'(sb.size()), 64'd0);
        wr(8'h03); wr(8'h0F);

        // Screen clear with a strobe raised while busy
        b0 = busy_cycles;
        w0 = writes;
        for (int i = 0; i < CELLS; i++) sb.push_back({12'(i), 16'h0F20});
        wr(8'h04);
        check("busy_during_fill", {63'd0, busy}, 64'd1);
        we = 1'b0;
        en = 1'b1;
        wait_ack(1'b1, n);
        check("pending_after_fill", 64'(writes - w0), 64'(CELLS));
        check("pending_not_busy", {63'd0, busy}, 64'd0);
        check("pending_status", {56'd0, status}, 64'h00);
        en = 1'b0;
        wait_ack(1'b0, n);
        check("fill_busy_cycles", 64'(busy_cycles - b0), 64'(CELLS));
        check("sb_drain_fill", 64'(sb.size()), 64'd0);
        check("cursor_after_clear", 64'(cursor), 64'd0);

        // Unknown opcode, status err bit, clear with NOP, status in ARG
        w0 = writes;
        wr(8'h7F);
        check("err_set", {63'd0, err}, 64'd1);
        rd(st);
        check("status_err", {56'd0, st}, 64'h80);
        wr(8'h00);
        check("err_clear", {63'd0, err}, 64'd0);
        rd(st);
        check("status_clear", {56'd0, st}, 64'h00);
        wr(8'h03);
        rd(st);
        check("status_arg", {56'd0, st}, 64'h01);
        wr(8'h0F);
        check("no_write_err_ops", 64'(writes - w0), 64'd0);

        // Asynchronous reset in the middle of a fill
        wr(8'h03); wr(8'h3C);
        wr(8'h55);
        sb_ignore = 1'b1;
        wr(8'h04);
        repeat (100) @(posedge clk);
        #3;
        check("busy_before_reset", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_fill", {12'd0, ack, busy, status, vram_we, vram_addr, vram_data, cursor, err}, 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        sb_ignore = 1'b0;
        @(posedge clk);
        #1;
        check("cursor_after_reset", 64'(cursor), 64'd0);
        rd(st);
        check("status_after_reset", {56'd0, st}, 64'h00);
        sb.push_back({12'd0, 16'h0F5A});
        wr(8'h02); wr(8'h5A);
        check("cursor_after_put", 64'(cursor), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("sb_final_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
